// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, RV32I opcodes,
// ALU operation codes and datapath select values.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_LOAD,
    CLS_STORE,
    CLS_ILLEGAL
  } op_class_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_RS1  = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;
  localparam logic [1:0] RES_ALU    = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_PC4    = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_code = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_code = ALU_SLL;
      3'd2:    alu_code = ALU_SLT;
      3'd3:    alu_code = ALU_SLTU;
      3'd4:    alu_code = ALU_XOR;
      3'd5:    alu_code = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_code = ALU_OR;
      default: alu_code = ALU_AND;
    endcase
  endfunction

  // func3 2 and 3 are not branch encodings; callers treat them as illegal.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
    case (f3)
      3'd0:    branch_taken = zero;
      3'd1:    branch_taken = !zero;
      3'd4:    branch_taken = lt;
      3'd5:    branch_taken = !lt;
      3'd6:    branch_taken = ltu;
      3'd7:    branch_taken = !ltu;
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_ctrl_decode.sv
// Combinational decode of the latched instruction fields and current state into
// datapath control strobes, plus the instruction class used by the FSM.
module ctrl_decode
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  state_e               state,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 mem_ready,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [2:0]           imm_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [2:0]           ls_type,
  output op_class_e            op_class
);

  logic [1:0] ex_src_a;
  logic [1:0] ex_src_b;
  logic [2:0] ex_imm;
  logic [3:0] ex_alu;

  always_comb begin
    op_class = CLS_ILLEGAL;
    ex_src_a = SRC_A_PC;
    ex_src_b = SRC_B_RS2;
    ex_imm   = IMM_I;
    ex_alu   = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
          op_class = CLS_ALU;
          ex_src_a = SRC_A_RS1;
          ex_alu   = alu_code(funct3, funct7[5]);
        end
      end
      OPC_OP_IMM: begin
        // Only the shift-immediate forms constrain func7; there is no SUBI.
        if ((funct3 != 3'd1 && funct3 != 3'd5) || funct7 == 7'h00 ||
            (funct3 == 3'd5 && funct7 == 7'h20)) begin
          op_class = CLS_ALU;
          ex_src_a = SRC_A_RS1;
          ex_src_b = SRC_B_IMM;
          ex_alu   = alu_code(funct3, funct3 == 3'd5 && funct7[5]);
        end
      end
      OPC_LUI: begin
        op_class = CLS_ALU;
        ex_src_a = SRC_A_ZERO;
        ex_src_b = SRC_B_IMM;
        ex_imm   = IMM_U;
      end
      OPC_AUIPC: begin
        op_class = CLS_ALU;
        ex_src_b = SRC_B_IMM;
        ex_imm   = IMM_U;
      end
      OPC_BRANCH: begin
        if (funct3 != 3'd2 && funct3 != 3'd3) begin
          op_class = CLS_BRANCH;
          ex_src_a = SRC_A_RS1;
          ex_imm   = IMM_B;
          ex_alu   = ALU_SUB;
        end
      end
      OPC_JAL: begin
        op_class = CLS_JUMP;
        ex_src_b = SRC_B_IMM;
        ex_imm   = IMM_J;
      end
      OPC_JALR: begin
        if (funct3 == 3'd0) begin
          op_class = CLS_JUMP;
          ex_src_a = SRC_A_RS1;
          ex_src_b = SRC_B_IMM;
        end
      end
      OPC_LOAD: begin
        if (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7) begin
          op_class = CLS_LOAD;
          ex_src_a = SRC_A_RS1;
          ex_src_b = SRC_B_IMM;
        end
      end
      OPC_STORE: begin
        if (funct3 <= 3'd2) begin
          op_class = CLS_STORE;
          ex_src_a = SRC_A_RS1;
          ex_src_b = SRC_B_IMM;
          ex_imm   = IMM_S;
        end
      end
      default: op_class = CLS_ILLEGAL;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    result_src  = 2'd0;
    imm_src     = 3'd0;
    alu_control = '0;
    ls_type     = 3'd0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_EXEC: begin
        if (op_class != CLS_ILLEGAL) begin
          alu_src_a   = ex_src_a;
          alu_src_b   = ex_src_b;
          imm_src     = ex_imm;
          alu_control = ALUCTRL_W'(ex_alu);
          if (op_class == CLS_BRANCH) pc_write = branch_taken(funct3, zero, lt, ltu);
          if (op_class == CLS_JUMP)   pc_write = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_class == CLS_STORE);
        ls_type = funct3;
      end
      S_WB: begin
        reg_write = (rd != 5'd0);
        if (op_class == CLS_LOAD)      result_src = RES_MEM;
        else if (op_class == CLS_JUMP) result_src = RES_PC4;
        else                           result_src = RES_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM with instruction register and retire counter.
// Define ILLEGAL_TRAP_EN to park in TRAP on illegal instructions; otherwise they retire as NOPs.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int RETIRE_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [31:0]          ir_q,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [2:0]           imm_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [2:0]           ls_type,
  output logic [2:0]           state_o,
  output logic [RETIRE_W-1:0]  retired,
  output logic                 illegal
);

  state_e                state_q, state_d;
  logic [31:0]           ir_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic                  illegal_q, illegal_d;
  op_class_e             op_class;

  ctrl_decode #(.ALUCTRL_W(ALUCTRL_W)) u_decode (
    .state      (state_q),
    .opcode     (ir_q[6:0]),
    .rd         (ir_q[11:7]),
    .funct3     (ir_q[14:12]),
    .funct7     (ir_q[31:25]),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .alu_control(alu_control),
    .ls_type    (ls_type),
    .op_class   (op_class)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op_class)
          CLS_BRANCH:           state_d = S_FETCH;
          CLS_LOAD, CLS_STORE:  state_d = S_MEM;
          CLS_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
            state_d   = S_TRAP;
            illegal_d = 1'b1;
`else
            state_d   = S_FETCH;
`endif
          end
          default:              state_d = S_WB;
        endcase
      end
      S_MEM:    if (mem_ready) state_d = (op_class == CLS_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
    if (ir_write) ir_d = instr;
    // An instruction retires exactly when control returns to FETCH after executing.
    if (state_d == S_FETCH && (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
      retired_d = retired_q + RETIRE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign state_o = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALUCTRL_W, default 4: width of alu_control; values 4..6.
REQ-002 Parameter RETIRE_W, default 32: width of the retired-instruction counter.
REQ-003 Ports: clk  in  1  sole clock, rising edge. rst  in  1  reset, asynchronous, active-high.
REQ-004 Ports: instr  in  32  memory read data, fetched instruction. mem_ready  in  1  memory handshake complete this cycle.
REQ-005 Ports: zero, lt, ltu  in  1 each  ALU compare flags (equal, signed less, unsigned less).
REQ-006 Ports: mem_req  out  1  memory access request. mem_we  out  1  store request. ir_write  out  1  latch instr.
REQ-007 Ports: pc_write  out  1  PC update. reg_write  out  1  register file write. ir_q  out  32  latched instruction.
REQ-008 Ports: alu_src_a  out  2  (0=PC, 1=rs1, 2=zero). alu_src_b  out  2  (0=rs2, 1=imm, 2=const 4).
REQ-009 Ports: result_src  out  2  (0=ALU, 1=mem, 2=PC+4). imm_src  out  3  (I,S,B,U,J = 0..4). alu_control  out  ALUCTRL_W.
REQ-010 Ports: ls_type  out  3  func3 of load/store. state_o  out  3  current state. retired  out  RETIRE_W  instruction count. illegal  out  1  sticky illegal flag.

Function
REQ-011 FSM states SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
REQ-012 IDLE -> FETCH unconditionally; in IDLE all control outputs are 0.
REQ-013 FETCH: mem_req=1; stay while mem_ready=0; on mem_ready=1 assert ir_write, latch instr into ir_q, go to DECODE.
REQ-014 DECODE: one cycle, no side effects, go to EXEC.
REQ-015 EXEC, OP/OP-IMM/LUI/AUIPC: drive ALU selects and alu_control from ir_q opcode/func3/func7[5], go to WB.
REQ-016 EXEC, BRANCH: taken = f(func3, zero, lt, ltu) per RV32I; pc_write=taken; go to FETCH.
REQ-017 EXEC, JAL/JALR: pc_write=1, go to WB with result_src=2.
REQ-018 EXEC, LOAD/STORE: address computed (rs1+imm), go to MEM.
REQ-019 MEM: mem_req=1, mem_we=1 for store, ls_type=func3; hold while mem_ready=0; on mem_ready=1 load -> WB (result_src=1), store -> FETCH.
REQ-020 WB: reg_write=1 for one cycle, go to FETCH; reg_write is forced 0 when rd=0.
REQ-021 Zero-wait latencies: branch 3, store 4, ALU/jump 4, load 5 cycles FETCH-to-FETCH.
REQ-022 retired increments by 1 on each transition back to FETCH from EXEC, MEM or WB; wraps modulo 2^RETIRE_W.
REQ-023 Unknown opcode or invalid func3/func7 combination SHALL be treated per REQ-028/029.
REQ-024 mem_ready is ignored outside FETCH and MEM.

Reset
REQ-025 While rst=1: state=IDLE, ir_q=0, retired=0, illegal=0, all outputs 0, independent of clk.
REQ-026 Reset asserted mid-access aborts it immediately; mem_req drops in the same cycle; no completion is recorded.
REQ-027 After rst deasserts, first mem_req asserts on the second rising edge (IDLE then FETCH).

Configuration
REQ-028 Macro ILLEGAL_TRAP_EN defined: illegal instruction in EXEC -> TRAP, illegal=1; TRAP holds with all controls 0 until reset; not counted in retired.
REQ-029 Macro absent: illegal instruction executes as NOP (EXEC -> FETCH, counted in retired); illegal stays 0; TRAP is unreachable.

Structure
REQ-030 Shared package SHALL hold state encoding, opcode constants, alu_control codes, and src/imm select encodings.
REQ-031 Sub-module ctrl_decode SHALL be the combinational decode of ir_q + state into control outputs; the FSM, ir_q, and counter live in the top.

Verification
REQ-032 add x3,x1,x2 (0x002081B3), mem_ready always 1 -> states 1,2,3,5,1; reg_write=1 in WB only; retired=1.
REQ-033 beq with zero=1 -> pc_write=1 in EXEC, next state FETCH; same with zero=0 -> pc_write=0.
REQ-034 lw (0x0000A183), mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0, result_src=1 in WB, ls_type=2.
REQ-035 sw (0x0020A023) -> mem_we=1 in MEM, no WB, reg_write never 1, retired +1.
REQ-036 instr 0xFFFFFFFF with ILLEGAL_TRAP_EN -> state 6, illegal=1, retired unchanged; without macro -> back to FETCH, illegal=0.
REQ-037 rst pulsed during FETCH wait -> mem_req=0 immediately, retired=0, fetch restarts two edges after release.
